// File: rtl/score_renderer.sv
// Sheet-music renderer: a per-frame layout engine classifies note slots into a glyph table,
// and a 4-stage pixel pipeline draws staff, clef, glyphs and playhead from that table and a sprite ROM.
module score_renderer #(
   parameter int NUM_SYSTEMS = 5,
   parameter int SLOTS       = 32,
   parameter int SLOT_W      = 32,
   parameter int SYS_H       = 100,
   parameter int X0          = 96,
   parameter int Y0          = 100
) (
   input  logic                                    pixel_clk_in,
   input  logic                                    rst_n_in,
   input  logic [10:0]                             hcount_in,
   input  logic [9:0]                              vcount_in,
   input  logic [NUM_SYSTEMS*SLOTS-1:0][5:0]       notes_in,
   input  logic                                    cursor_en_in,
   input  logic [$clog2(NUM_SYSTEMS*SLOTS)-1:0]    cursor_slot_in,
   output logic [7:0]                              red_out,
   output logic [7:0]                              green_out,
   output logic [7:0]                              blue_out,
   output logic                                    layout_busy_out
);
   localparam int N      = NUM_SYSTEMS*SLOTS;
   localparam int GW     = $clog2(N);
   localparam int GB     = SLOT_W*SYS_H;
   localparam int ROM_AW = $clog2(11*GB);
   localparam int VXW    = $clog2(SLOT_W);
   localparam int VYW    = $clog2(SYS_H);

   // kind: 0 = blank, otherwise glyph index + 1; acc: 0 none, 1 natural, 2 sharp
   typedef struct packed {
      logic [3:0] kind;
      logic [1:0] acc;
      logic       ledger;
      logic [3:0] step;
   } entry_t;

   typedef struct packed {
      logic           in_rgn, clef, slot;
      logic [GW-1:0]  g;
      logic [VXW-1:0] vx;
      logic [VYW-1:0] vy;
      logic           line, cur;
   } s1_t;

   typedef struct packed {
      logic           in_rgn, clef, slot;
      logic [VXW-1:0] vx;
      logic [VYW-1:0] vy;
      logic           line, cur;
      entry_t         ent;
   } s2_t;

   typedef struct packed {
      logic              in_rgn, black, cur, main_ok, acc_ok;
      logic [ROM_AW-1:0] main_addr, acc_addr;
   } s3_t;

   typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} state_t;

   // ---------------- reset synchroniser ----------------
   logic [1:0] rsync_q, rsync_d;
   logic       rst_n;
   assign rsync_d = {rsync_q[0], 1'b1};
   assign rst_n   = rsync_q[1];
   always_ff @(posedge pixel_clk_in or negedge rst_n_in)
      if (!rst_n_in) rsync_q <= '0;
      else           rsync_q <= rsync_d;

   // ---------------- helpers ----------------
   function automatic logic same_f(input logic [N-1:0][5:0] sh, input int a, input int b);
      logic [5:0] x, y;
      if (a < 0 || b < 0 || a >= N || b >= N) return 1'b0;
      x = sh[GW'(a)];
      y = sh[GW'(b)];
      if (!x[5] && !y[5]) return 1'b1;
      return x[5] && y[5] && (x == y);
   endfunction

   // returns {is_sharp, staff step}
   function automatic logic [4:0] step_f(input logic [4:0] semi);
      logic [4:0] r;
      case (semi)
         5'd0:  r = {1'b0, 4'd0};   5'd1:  r = {1'b1, 4'd0};
         5'd2:  r = {1'b0, 4'd1};   5'd3:  r = {1'b1, 4'd1};
         5'd4:  r = {1'b0, 4'd2};   5'd5:  r = {1'b0, 4'd3};
         5'd6:  r = {1'b1, 4'd3};   5'd7:  r = {1'b0, 4'd4};
         5'd8:  r = {1'b1, 4'd4};   5'd9:  r = {1'b0, 4'd5};
         5'd10: r = {1'b1, 4'd5};   5'd11: r = {1'b0, 4'd6};
         5'd12: r = {1'b0, 4'd7};   5'd13: r = {1'b1, 4'd7};
         5'd14: r = {1'b0, 4'd8};   5'd15: r = {1'b1, 4'd8};
         5'd16: r = {1'b0, 4'd9};   5'd17: r = {1'b0, 4'd10};
         5'd18: r = {1'b1, 4'd10};  5'd19: r = {1'b0, 4'd11};
         5'd20: r = {1'b1, 4'd11};  5'd21: r = {1'b0, 4'd12};
         default: r = '0;
      endcase
      return r;
   endfunction

   // 1-bit sprite ROM, 0 = ink. Note heads sit on ROM rows 70..76 so step s lands 4*s rows higher.
   function automatic logic rom_f(input logic [ROM_AW-1:0] a);
      int gl, rem, r, c;
      logic ink;
      gl  = int'(a) / GB;
      rem = int'(a) % GB;
      r   = rem / SLOT_W;
      c   = rem % SLOT_W;
      case (gl)
         0, 1, 2, 3: ink = (r >= 70 && r <= 76 && c >= 9 && c <= 22) ||
                           (gl != 0 && c == 22 && r >= 45 && r < 70) ||
                           (gl == 3 && r >= 45 && r <= 48 && c >= 23 && c <= 26);
         4:  ink = r >= 45 && r <= 48 && c >= 10 && c <= 21;
         5:  ink = r >= 49 && r <= 52 && c >= 10 && c <= 21;
         6:  ink = r >= 45 && r <= 60 && c >= 14 && c <= 17;
         7:  ink = r >= 49 && r <= 56 && c >= 12 && c <= 19;
         8:  ink = (c == 2 || c == 7) && r >= 66 && r <= 80;
         9:  ink = ((r == 70 || r == 71 || r == 76 || r == 77) && c >= 1 && c <= 8) ||
                   ((c == 3 || c == 6) && r >= 66 && r <= 80);
         10: ink = (c == 15 || c == 16) && r >= 20 && r <= 80;
         default: ink = 1'b0;
      endcase
      return !ink;
   endfunction

   // ---------------- layout FSM ----------------
   state_t state_q, state_d;
   logic   trig, scan_we;
   logic [GW-1:0]          g_q, g_d;
   logic [N-1:0][5:0]      shadow_q, shadow_d;
   logic [12:0]            sharp_q, sharp_d;
   entry_t [N-1:0]         glyph_tab_q, glyph_tab_d;

   assign trig = (hcount_in == 11'd0) && (vcount_in == 10'(Y0 + NUM_SYSTEMS*SYS_H));

   always_ff @(posedge pixel_clk_in or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trig) state_d = SNAP;
         SNAP:    state_d = SCAN;
         SCAN:    if (g_q == GW'(N-1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      layout_busy_out = (state_q == SNAP) || (state_q == SCAN);
      scan_we         = (state_q == SCAN);
   end

   // ---------------- slot classifier ----------------
   logic [7:1]  fwd;
   logic [4:1]  bwd;
   logic [2:0]  p;
   logic [5:0]  cur_note;
   logic [4:0]  sinfo;
   logic [1:0]  dur, acc;
   logic        blank;
   logic [12:0] sharp_base;
   entry_t      ent_new;

   always_comb begin
      p        = g_q[2:0];
      cur_note = shadow_q[g_q];
      sinfo    = step_f(cur_note[4:0]);
      for (int k = 1; k < 8; k++) fwd[k] = same_f(shadow_q, int'(g_q), int'(g_q) + k);
      for (int k = 1; k < 5; k++) bwd[k] = same_f(shadow_q, int'(g_q), int'(g_q) - k);
      blank = 1'b0;
      dur   = 2'd3;
      case (p)
         3'd0: begin
            if (&fwd[7:1])      dur = 2'd0;
            else if (&fwd[3:1]) dur = 2'd1;
            else if (fwd[1])    dur = 2'd2;
         end
         3'd2, 3'd6: begin
            if (!fwd[1])               dur = 2'd3;
            else if (bwd[2] && bwd[1]) blank = 1'b1;
            else                       dur = 2'd2;
         end
         3'd4: begin
            if (!fwd[1])                dur = 2'd3;
            else if (!(fwd[2] && fwd[3])) dur = 2'd2;
            else if (&bwd[4:1])         blank = 1'b1;
            else                        dur = 2'd1;
         end
         default: blank = bwd[1];
      endcase

      // accidental state runs over every slot, blank or not, and restarts each measure
      sharp_base = (p == 3'd0) ? 13'd0 : sharp_q;
      sharp_d    = scan_we ? sharp_base : sharp_q;
      acc        = 2'd0;
      if (cur_note[5]) begin
         if (sinfo[4]) begin
            if (!sharp_base[sinfo[3:0]]) acc = 2'd2;
            if (scan_we) sharp_d[sinfo[3:0]] = 1'b1;
         end else begin
            if (sharp_base[sinfo[3:0]]) acc = 2'd1;
            if (scan_we) sharp_d[sinfo[3:0]] = 1'b0;
         end
      end

      ent_new = '0;
      if (!blank) begin
         ent_new.kind   = 4'({~cur_note[5], dur}) + 4'd1;
         ent_new.acc    = acc;
         ent_new.ledger = cur_note[5] && (cur_note[4:0] == 5'd21 || cur_note[4:0] <= 5'd1);
         ent_new.step   = cur_note[5] ? sinfo[3:0] : 4'd0;
      end
   end

   always_comb begin
      g_d         = (scan_we && g_q != GW'(N-1)) ? g_q + GW'(1) : '0;
      shadow_d    = (state_q == SNAP) ? notes_in : shadow_q;
      glyph_tab_d = glyph_tab_q;
      if (scan_we) glyph_tab_d[g_q] = ent_new;
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n)
      if (!rst_n) begin
         g_q         <= '0;
         shadow_q    <= '0;
         sharp_q     <= '0;
         glyph_tab_q <= '0;
      end else begin
         g_q         <= g_d;
         shadow_q    <= shadow_d;
         sharp_q     <= sharp_d;
         glyph_tab_q <= glyph_tab_d;
      end

   // ---------------- pixel pipeline ----------------
   s1_t         s1_q, s1_d;
   s2_t         s2_q, s2_d;
   s3_t         s3_q, s3_d;
   logic [23:0] rgb_q, rgb_d;
   logic [2:0]  vld_pipe_q, vld_pipe_d;
   int          dx, dy, col, sl, sysi, vyi, row, vxi;
   logic        staff, bar, nb, led, mb, ab;
   entry_t      e;

   // P1: position decode
   always_comb begin
      dx   = int'(hcount_in) - X0;
      dy   = int'(vcount_in) - Y0;
      sysi = 0;
      for (int s = 1; s < NUM_SYSTEMS; s++) if (dy >= s*SYS_H) sysi = s;
      col  = dx / SLOT_W;
      sl   = col - 1;
      vyi  = dy - sysi*SYS_H;
      s1_d = '0;
      s1_d.in_rgn = dx >= 0 && dx <= SLOT_W*(SLOTS+1) && dy >= 0 && dy < NUM_SYSTEMS*SYS_H;
      s1_d.clef   = s1_d.in_rgn && col == 0;
      s1_d.slot   = s1_d.in_rgn && col >= 1 && col <= SLOTS;
      s1_d.g      = GW'(sysi*SLOTS + sl);
      s1_d.vx     = VXW'(dx % SLOT_W);
      s1_d.vy     = VYW'(vyi);
      staff = vyi == 33 || vyi == 41 || vyi == 49 || vyi == 57 || vyi == 65;
      bar   = ((s1_d.slot && dx % SLOT_W == 0 && sl % 8 == 0 && sl != 0) ||
               (s1_d.in_rgn && col == SLOTS+1)) && vyi >= 33 && vyi <= 65;
      s1_d.line = s1_d.in_rgn && (staff || bar);
      s1_d.cur  = cursor_en_in && s1_d.slot && (s1_d.g == cursor_slot_in);
   end

   // P2: table read
   always_comb begin
      s2_d.in_rgn = s1_q.in_rgn;
      s2_d.clef   = s1_q.clef;
      s2_d.slot   = s1_q.slot;
      s2_d.vx     = s1_q.vx;
      s2_d.vy     = s1_q.vy;
      s2_d.line   = s1_q.line;
      s2_d.cur    = s1_q.cur;
      s2_d.ent    = s1_q.slot ? glyph_tab_q[s1_q.g] : '0;
   end

   // P3: ROM addresses and ledger overlay
   always_comb begin
      e    = s2_q.ent;
      nb   = s2_q.slot && e.kind != 4'd0;
      vxi  = int'(s2_q.vx);
      row  = int'(s2_q.vy) + 4*int'(e.step);
      s3_d = '0;
      s3_d.in_rgn = s2_q.in_rgn;
      s3_d.cur    = s2_q.cur;
      if (s2_q.clef) begin
         s3_d.main_ok   = 1'b1;
         s3_d.main_addr = ROM_AW'(10*GB + int'(s2_q.vy)*SLOT_W + vxi);
      end else if (nb) begin
         s3_d.main_ok   = row < SYS_H;
         s3_d.main_addr = ROM_AW'((int'(e.kind) - 1)*GB + row*SLOT_W + vxi);
      end
      if (nb && e.acc != 2'd0) begin
         s3_d.acc_ok   = row < SYS_H && (e.acc == 2'd1 || int'(s2_q.vy) < 77);
         s3_d.acc_addr = ROM_AW'((e.acc == 2'd2 ? 9 : 8)*GB + row*SLOT_W + vxi);
      end
      led = nb && e.ledger && vxi >= 9 && vxi <= 26 &&
            (e.step == 4'd12 ? int'(s2_q.vy) == 25 : int'(s2_q.vy) == 73);
      s3_d.black = s2_q.line || led;
   end

   // P4: ROM lookup and colour
   always_comb begin
      mb         = s3_q.main_ok ? rom_f(s3_q.main_addr) : 1'b1;
      ab         = s3_q.acc_ok  ? rom_f(s3_q.acc_addr)  : 1'b1;
      vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
      rgb_d      = 24'h000000;
      if (vld_pipe_q[2] && s3_q.in_rgn && !s3_q.black && mb && ab)
         rgb_d = s3_q.cur ? 24'hC0C0FF : 24'hFFFFFF;
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n)
      if (!rst_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         rgb_q      <= '0;
         vld_pipe_q <= '0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         rgb_q      <= rgb_d;
         vld_pipe_q <= vld_pipe_d;
      end

   assign {red_out, green_out, blue_out} = rgb_q;
endmodule

// File: tb/tb_score_renderer.sv
// Directed bench for score_renderer: layout table contents, pixel colours, latency and reset abort.
module tb_score_renderer;
   logic              clk = 1'b0;
   logic              rst_n;
   logic [10:0]       hc;
   logic [9:0]        vc;
   logic [159:0][5:0] notes;
   logic              cur_en;
   logic [7:0]        cur_slot;
   logic [7:0]        red, green, blue;
   logic              busy;
   int                n_run = 0, n_fail = 0;
   int                cnt;

   always #5 clk = ~clk;

   score_renderer dut (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hc), .vcount_in(vc),
      .notes_in(notes), .cursor_en_in(cur_en), .cursor_slot_in(cur_slot),
      .red_out(red), .green_out(green), .blue_out(blue), .layout_busy_out(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] mk(input int k, input int a, input int l, input int s);
      return {4'(k), 2'(a), 1'(l), 4'(s)};
   endfunction

   function automatic logic [10:0] ent(input int i);
      return dut.glyph_tab_q[i];
   endfunction

   // drive a pixel position and sample the colour exactly 4 clocks later
   task automatic px(input string tag, input int h, input int v, input logic [23:0] exp);
      hc = 11'(h);
      vc = 10'(v);
      repeat (4) @(posedge clk);
      #1;
      chk(tag, {8'h0, red, green, blue}, {8'h0, exp});
   endtask

   // fire the frame trigger and count layout_busy_out cycles; notes_in[0] is disturbed mid-scan
   task automatic frame(output int n);
      logic [5:0] save;
      save = notes[0];
      hc = 11'd0;
      vc = 10'd600;
      @(posedge clk);
      #1;
      hc = 11'd5;
      vc = 10'd5;
      n = 0;
      while (busy && n < 400) begin
         n++;
         if (n == 5) notes[0] = 6'h00;
         @(posedge clk);
         #1;
      end
      notes[0] = save;
   endtask

   initial begin
      rst_n    = 1'b0;
      hc       = 11'd5;
      vc       = 10'd5;
      notes    = '0;
      cur_en   = 1'b0;
      cur_slot = 8'd0;
      #23 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_e0", 32'(ent(0)), 32'd0);
      px("rst_staff", 298, 133, 24'h000000);
      px("rst_blank", 298, 120, 24'hFFFFFF);
      px("rst_outside", 10, 10, 24'h000000);

      // exact latency: black pixel held, then switch to white
      hc = 11'd298;
      vc = 10'd120;
      repeat (3) @(posedge clk);
      #1 chk("lat3", {8'h0, red, green, blue}, 32'h000000);
      @(posedge clk);
      #1 chk("lat4", {8'h0, red, green, blue}, 32'hFFFFFF);

      for (int i = 0; i < 8; i++) notes[i] = 6'h2C;
      notes[16] = 6'h21; notes[17] = 6'h20; notes[18] = 6'h21; notes[19] = 6'h21;
      notes[31] = 6'h35;

      frame(cnt);
      chk("busy_len", 32'(cnt), 32'd161);
      chk("e0_whole", 32'(ent(0)), 32'(mk(1, 0, 0, 7)));
      chk("e1_blank", 32'(ent(1)), 32'd0);
      chk("e7_blank", 32'(ent(7)), 32'd0);
      chk("e8_wrest", 32'(ent(8)), 32'(mk(5, 0, 0, 0)));
      chk("e16_sharp", 32'(ent(16)), 32'(mk(4, 2, 1, 0)));
      chk("e17_nat", 32'(ent(17)), 32'(mk(4, 1, 1, 0)));
      chk("e18_quarter", 32'(ent(18)), 32'(mk(3, 2, 1, 0)));
      chk("e19_blank", 32'(ent(19)), 32'd0);
      chk("e20_hrest", 32'(ent(20)), 32'(mk(6, 0, 0, 0)));
      chk("e24_hrest", 32'(ent(24)), 32'(mk(6, 0, 0, 0)));
      chk("e31_a5", 32'(ent(31)), 32'(mk(4, 0, 1, 12)));

      px("head_ink", 143, 145, 24'h000000);
      px("ledger_a5", 1132, 125, 24'h000000);
      px("bar_slot8", 384, 140, 24'h000000);
      px("nobar_slot9", 416, 140, 24'hFFFFFF);

      notes[31] = 6'h2C;
      frame(cnt);
      chk("e31_c5", 32'(ent(31)), 32'(mk(4, 0, 0, 7)));
      px("noledger_c5", 1132, 125, 24'hFFFFFF);

      cur_en   = 1'b1;
      cur_slot = 8'd3;
      px("cursor_blank", 234, 120, 24'hC0C0FF);
      px("cursor_staff", 234, 133, 24'h000000);
      px("cursor_other", 266, 120, 24'hFFFFFF);

      // reset in the middle of a scan
      hc = 11'd0;
      vc = 10'd600;
      @(posedge clk);
      #1;
      hc = 11'd234;
      vc = 10'd120;
      repeat (50) @(posedge clk);
      #1 chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_rgb", {8'h0, red, green, blue}, 32'hC0C0FF);
      #2 rst_n = 1'b0;
      #1 chk("rst_scan_busy", 32'(busy), 32'd0);
      chk("rst_scan_rgb", {8'h0, red, green, blue}, 32'h000000);
      #10 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("abandon_e0", 32'(ent(0)), 32'd0);
      chk("abandon_busy", 32'(busy), 32'd0);

      frame(cnt);
      chk("rebuild_len", 32'(cnt), 32'd161);
      chk("rebuild_e0", 32'(ent(0)), 32'(mk(1, 0, 0, 7)));
      chk("rebuild_e18", 32'(ent(18)), 32'(mk(3, 2, 1, 0)));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
